// File: rtl/reg_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback path.
// Pure definitions: no logic, no latency, no backpressure.
package reg_pkg;

    localparam int NUM_REQ    = 3;
    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int ZERO_REG   = 0;

    typedef enum logic [1:0] {
        REQ_ALU  = 2'd0,
        REQ_LOAD = 2'd1,
        REQ_MDU  = 2'd2
    } req_id_e;

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// Writeback requests, reservation marks, register-file write port and busy scoreboard.
// Wires only; timing and backpressure are defined by the arbiter behind the slave modport.
interface reg_wb_arbiter_if #(
    parameter int NUM_REQ    = reg_pkg::NUM_REQ,
    parameter int DATA_WIDTH = reg_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = reg_pkg::ADDR_WIDTH
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_waddr;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
    logic                          mark_valid;
    logic [ADDR_WIDTH-1:0]         mark_addr;
    logic                          rf_wen;
    logic [ADDR_WIDTH-1:0]         rf_waddr;
    logic [DATA_WIDTH-1:0]         rf_wdata;
    logic [31:0]                   busy_vec;

    modport master (
        output req_valid, req_waddr, req_wdata, mark_valid, mark_addr,
        input  req_ready, rf_wen, rf_waddr, rf_wdata, busy_vec
    );

    modport slave (
        input  req_valid, req_waddr, req_wdata, mark_valid, mark_addr,
        output req_ready, rf_wen, rf_waddr, rf_wdata, busy_vec
    );
endinterface

// File: rtl/reg_wb_arbiter_rr.sv
// Round-robin arbiter: combinational one-hot grant from a registered priority pointer.
// Zero latency; grants whenever any request is valid, pointer moves past the winner.
module rr_arbiter #(
    parameter int N = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] grant_idx_o,
    output logic          grant_vld_o
);
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cidx;
    int            cand;

    // Walk offsets from farthest to nearest so the nearest valid requester is written last.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        grant_vld_o = 1'b0;
        cand        = 0;
        cidx        = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = int'(ptr_q) + k;
            if (cand >= N) cand = cand - N;
            cidx = IW'(cand);
            if (req_i[cidx]) begin
                grant_idx_o = cidx;
                grant_vld_o = 1'b1;
            end
        end
        if (grant_vld_o) grant_o[grant_idx_o] = 1'b1;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (grant_vld_o) begin
            ptr_d = (grant_idx_o == IW'(N - 1)) ? '0 : grant_idx_o + IW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
endmodule

// File: rtl/reg_wb_arbiter.sv
// Shares the single register-file write port among NUM_REQ writeback units and tracks busy registers.
// One cycle accept-to-write; never stalls, so any valid request is accepted in its cycle.
module reg_wb_arbiter #(
    parameter int NUM_REQ    = reg_pkg::NUM_REQ,
    parameter int DATA_WIDTH = reg_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = reg_pkg::ADDR_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    reg_wb_arbiter_if.slave bus
);
    import reg_pkg::*;

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    grant;
    logic [IW-1:0]         grant_idx;
    logic                  grant_vld;
    logic [ADDR_WIDTH-1:0] sel_waddr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    logic                  rf_wen_q,   rf_wen_d;
    logic [ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
    logic [31:0]           busy_q,     busy_d;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk         (clk),
        .rst         (rst),
        .req_i       (bus.req_valid),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .grant_vld_o (grant_vld)
    );

    assign bus.req_ready = rst ? '0 : grant;

    always_comb begin
        sel_waddr = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == IW'(i)) begin
                sel_waddr = bus.req_waddr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = bus.req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // x0 writes are accepted and registered but never enable the register file.
    always_comb begin
        rf_wen_d   = grant_vld && (sel_waddr != ADDR_WIDTH'(ZERO_REG));
        rf_waddr_d = grant_vld ? sel_waddr : rf_waddr_q;
        rf_wdata_d = grant_vld ? sel_wdata : rf_wdata_q;
    end

    // Clear before set: a fresh reservation outranks the retiring write to the same register.
    always_comb begin
        busy_d = busy_q;
        if (rf_wen_q) busy_d[rf_waddr_q] = 1'b0;
        if (bus.mark_valid && (bus.mark_addr != ADDR_WIDTH'(ZERO_REG))) begin
            busy_d[bus.mark_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_wen_q   <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            busy_q     <= '0;
        end else begin
            rf_wen_q   <= rf_wen_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.rf_wen   = rf_wen_q;
    assign bus.rf_waddr = rf_waddr_q;
    assign bus.rf_wdata = rf_wdata_q;
    assign bus.busy_vec = busy_q;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Randomized bench for reg_wb_arbiter: a high-level model queues expected responses,
// a negedge monitor pops and compares them.
module tb_reg_wb_arbiter;
    import reg_pkg::*;

    localparam int N  = NUM_REQ;
    localparam int AW = ADDR_WIDTH;
    localparam int DW = DATA_WIDTH;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_wb_arbiter_if bus ();

    reg_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } rf_t;

    int n_pass  = 0;
    int n_total = 0;

    bit [N-1:0]  ready_q[$];
    rf_t         rf_q[$];
    logic [31:0] busy_q[$];
    bit          mon_en = 1'b0;

    // Requester and issue-stage state as the bench sees it.
    bit            pend[N];
    logic [AW-1:0] p_addr[N];
    logic [DW-1:0] p_data[N];
    bit            m_v;
    logic [AW-1:0] m_a;

    // Reference model: priority pointer, busy set, current register-file output.
    int          ptr;
    logic [31:0] busy_m;
    rf_t         rf_m;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]           = pend[i];
            bus.req_waddr[i*AW +: AW]  = p_addr[i];
            bus.req_wdata[i*DW +: DW]  = p_data[i];
        end
        bus.mark_valid = m_v;
        bus.mark_addr  = m_a;
    endtask

    task automatic step(input bit gen);
        int          g;
        int          idx;
        bit [N-1:0]  er;
        rf_t         nxt;
        logic [31:0] b;
        @(posedge clk);
        #1;
        if (gen) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i]   = 1'b1;
                    p_addr[i] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom_range(1, 31));
                    p_data[i] = $urandom;
                end
            end
            m_v = ($urandom_range(0, 2) == 0);
            m_a = AW'($urandom_range(0, 31));
        end
        drive();
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (ptr + k) % N;
            if (g < 0 && pend[idx]) g = idx;
        end
        er  = '0;
        nxt = rf_m;
        nxt.wen = 1'b0;
        if (g >= 0) begin
            er[g]    = 1'b1;
            nxt.wen  = (p_addr[g] != 0);
            nxt.addr = p_addr[g];
            nxt.data = p_data[g];
            ptr      = (g + 1) % N;
            pend[g]  = 1'b0;
        end
        b = busy_m;
        if (rf_m.wen) b[rf_m.addr] = 1'b0;
        if (m_v && m_a != 0) b[m_a] = 1'b1;
        ready_q.push_back(er);
        rf_q.push_back(nxt);
        busy_q.push_back(b);
        rf_m   = nxt;
        busy_m = b;
        m_v    = 1'b0;
        mon_en = 1'b1;
    endtask

    task automatic reset_model();
        ptr    = 0;
        busy_m = '0;
        rf_m   = '{wen: 1'b0, addr: '0, data: '0};
        ready_q.delete();
        rf_q.delete();
        busy_q.delete();
        for (int i = 0; i < N; i++) begin
            pend[i]   = 1'b0;
            p_addr[i] = '0;
            p_data[i] = '0;
        end
        m_v = 1'b0;
        m_a = '0;
        drive();
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        rf_q.push_back(rf_m);
        busy_q.push_back(busy_m);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_rf_wen"},    bus.rf_wen,    0);
        check({tag, "_rf_waddr"},  bus.rf_waddr,  0);
        check({tag, "_rf_wdata"},  bus.rf_wdata,  0);
        check({tag, "_busy_vec"},  bus.busy_vec,  0);
        check({tag, "_req_ready"}, bus.req_ready, 0);
    endtask

    task automatic all_valid_burst(input int cycles);
        for (int c = 0; c < cycles; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!pend[i]) begin
                    pend[i]   = 1'b1;
                    p_addr[i] = AW'(i + 1);
                    p_data[i] = $urandom;
                end
            end
            step(1'b0);
        end
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
    endtask

    bit [N-1:0]  mon_er;
    rf_t         mon_rf;
    logic [31:0] mon_b;

    always @(negedge clk) begin
        if (mon_en) begin
            if (ready_q.size() == 0 || rf_q.size() == 0 || busy_q.size() == 0) begin
                n_total++;
                $display("FAIL queue_underflow: got empty expectation queue, required an entry at %0t", $time);
            end else begin
                mon_er = ready_q.pop_front();
                mon_rf = rf_q.pop_front();
                mon_b  = busy_q.pop_front();
                check("req_ready", bus.req_ready, mon_er);
                check("rf_wen",    bus.rf_wen,    mon_rf.wen);
                check("rf_waddr",  bus.rf_waddr,  mon_rf.addr);
                check("rf_wdata",  bus.rf_wdata,  mon_rf.data);
                check("busy_vec",  bus.busy_vec,  mon_b);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_model();
        #1;
        rst = 1'b1;
        bus.req_valid = '1;
        #2;
        check_zero("por");
        reset_model();
        release_reset();

        // Round-robin from pointer 0 with addresses 1/2/3.
        all_valid_burst(6);
        step(1'b0);

        // Single write from the load unit.
        pend[REQ_LOAD]   = 1'b1;
        p_addr[REQ_LOAD] = AW'(5);
        p_data[REQ_LOAD] = 32'hDEADBEEF;
        step(1'b0);
        step(1'b0);
        step(1'b0);

        // Reserve x7, retire it, then reserve again in the retiring cycle.
        m_v = 1'b1; m_a = AW'(7);
        step(1'b0);
        step(1'b0);
        pend[REQ_MDU] = 1'b1; p_addr[REQ_MDU] = AW'(7); p_data[REQ_MDU] = $urandom;
        step(1'b0);
        step(1'b0);
        step(1'b0);
        m_v = 1'b1; m_a = AW'(7);
        step(1'b0);
        pend[REQ_MDU] = 1'b1; p_addr[REQ_MDU] = AW'(7); p_data[REQ_MDU] = $urandom;
        step(1'b0);
        m_v = 1'b1; m_a = AW'(7);
        step(1'b0);
        step(1'b0);
        step(1'b0);

        // x0 write and x0 mark.
        pend[REQ_ALU] = 1'b1; p_addr[REQ_ALU] = '0; p_data[REQ_ALU] = 32'h12345678;
        step(1'b0);
        step(1'b0);
        m_v = 1'b1; m_a = '0;
        step(1'b0);
        step(1'b0);

        repeat (400) step(1'b1);
        repeat (4) step(1'b0);

        // Mid-stream reset while a write is in flight with x3 and x9 reserved.
        m_v = 1'b1; m_a = AW'(3);
        step(1'b0);
        m_v = 1'b1; m_a = AW'(9);
        step(1'b0);
        pend[REQ_ALU] = 1'b1; p_addr[REQ_ALU] = AW'(5); p_data[REQ_ALU] = 32'hCAFEF00D;
        step(1'b0);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        check("pre_rst_rf_wen", bus.rf_wen,      1);
        check("pre_rst_busy3",  bus.busy_vec[3], 1);
        check("pre_rst_busy9",  bus.busy_vec[9], 1);
        bus.req_valid = '1;
        rst = 1'b1;
        #1;
        check_zero("mid_rst");
        reset_model();
        release_reset();
        all_valid_burst(6);
        repeat (3) step(1'b0);

        @(negedge clk);
        #1;
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/reg_wb_arbiter.md
# reg_wb_arbiter

Writeback arbiter and scoreboard for the 32×32 register file, which has a single write port. It shares that port between NUM_REQ writeback requesters (ALU, load unit, mul/div unit) using round-robin arbitration with a valid/ready handshake. The winning write is registered before it drives the register file. A 32-bit busy scoreboard tracks destination registers with outstanding writes so that issue logic can detect RAW hazards.

## Interface
Parameters:
- NUM_REQ, 3: number of writeback requesters.
- DATA_WIDTH, 32: write data width.
- ADDR_WIDTH, 5: register address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  requester i has a write pending.
- req_ready  out  NUM_REQ  requester i's write is accepted this cycle (one-hot or zero).
- req_waddr  in  NUM_REQ*ADDR_WIDTH  flattened destination addresses; requester i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  flattened write data, same packing.
- mark_valid  in  1  issue stage reserves a destination register.
- mark_addr  in  ADDR_WIDTH  register being reserved.
- rf_wen  out  1  register file write enable.
- rf_waddr  out  ADDR_WIDTH  register file write address.
- rf_wdata  out  DATA_WIDTH  register file write data.
- busy_vec  out  32  bit r is 1 while register r has an outstanding write.

## Operation
- Arbitration is round-robin. The priority pointer starts at 0. The search begins at the pointer and wraps modulo NUM_REQ. The first requester with valid set is granted.
- After a grant to requester g, the pointer becomes (g+1) mod NUM_REQ. The pointer does not change when there is no grant.
- req_ready is combinational: req_ready[g] = grant[g]. At most one bit is high. The output stage never stalls, so every cycle with any valid produces exactly one grant.
- Handshake: a requester holds valid, waddr and wdata stable until it sees ready in the same cycle. It may deassert valid in the cycle after acceptance. Dropping valid before acceptance is illegal.
- The output stage registers the granted waddr/wdata on the next edge. rf_wen=1 if the granted waddr≠0, otherwise 0.
- A write to x0 is accepted and dropped: ready is asserted, rf_wen stays 0, busy_vec is unchanged.
- When no grant occurs, rf_wen=0 on the next edge. rf_waddr and rf_wdata hold their previous values.
- Scoreboard set: at an edge with mark_valid=1 and mark_addr≠0, busy_vec[mark_addr] is set to 1. A mark to x0 is ignored.
- Scoreboard clear: at an edge where rf_wen=1, busy_vec[rf_waddr] is cleared to 0.
- Simultaneous set and clear of the same register: set wins, because a new producer has been issued.
- busy_vec[0] is always 0.

## Timing
- Reset (asynchronous assert, deasserted synchronously by the top level):
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - busy_vec=0, pointer=0.
  - req_ready is forced to 0 while rst=1.
- Latency from acceptance to register-file write: 1 cycle. If ready is high in cycle t, rf_wen is high in cycle t+1, and the register file writes at the end of t+1.
- The busy bit clears at the same edge where the register file writes. It reads 0 from cycle t+2.
- Throughput: 1 write per cycle.
- Fairness: a continuously valid requester waits at most NUM_REQ-1 cycles.
- Reset mid-stream: the in-flight registered write is discarded (rf_wen drops immediately) and all busy bits clear. Requesters must re-present after reset.

## Structure
- Shared package reg_pkg holds:
  - DATA_WIDTH, ADDR_WIDTH, NUM_REQ.
  - Requester indices REQ_ALU=0, REQ_LOAD=1, REQ_MDU=2.
  - The zero-register constant.
- One sub-module, rr_arbiter. It holds the priority pointer register and the grant logic, parameterised by N, and outputs a one-hot grant vector and the granted index.
- reg_wb_arbiter contains the request mux, the output register stage and the scoreboard.

## Test plan
- Reset: assert rst asynchronously mid-cycle → rf_wen, rf_waddr, rf_wdata, busy_vec and req_ready read 0 immediately, with no clock edge needed.
- Single write: requester 1 presents waddr=5, wdata=0xDEADBEEF at cycle t → req_ready=3'b010 at t; rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF at t+1 only.
- Round-robin: all three requesters continuously valid with addresses 1/2/3 → grants 0,1,2,0,1,2 on consecutive cycles; rf_waddr follows 1,2,3,1,2,3.
- Scoreboard: mark 7 → busy_vec[7]=1 next cycle. A later writeback of 7 clears the bit after its rf_wen cycle. mark 7 in the same cycle as rf_wen to 7 → busy_vec[7] stays 1.
- x0 handling: requester 0 writes to addr 0 → ready asserted, rf_wen stays 0. mark_addr=0 → busy_vec stays 0.
- Reset mid-stream: rst during an rf_wen=1 cycle with busy bits 3 and 9 set → all cleared. After release, the first grant with all requesters valid goes to requester 0.
